pc_fetch_sequencer: RTL
=======================

Name: pc_fetch_sequencer

Overview:
- Owns the program counter and sequences instruction fetch through a req/ack handshake with instruction memory.
- Selects the next PC from three sources: sequential PC+4, a jump target built from a 28-bit shifted field, or a full 32-bit branch target.
- Captures redirects that arrive while a fetch is outstanding and applies them at fetch completion.
- Sits between the control unit and instruction memory; replaces the free-running PC register plus next-PC select.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  asynchronous, active-high reset.
- stall_i  input  1  pipeline hold request from downstream.
- jump_i  input  1  jump request, single-cycle pulse.
- jump_addr_i  input  28  jump field, already shifted left by 2.
- branch_i  input  1  taken-branch request, single-cycle pulse.
- branch_target_i  input  32  branch target address.
- imem_ack_i  input  1  instruction memory has returned data for pc_o.
- pc_o  output  32  current fetch address.
- imem_req_o  output  1  fetch request for pc_o.
- instr_valid_o  output  1  fetched instruction accepted this cycle.
- redirect_pending_o  output  1  a captured redirect not yet applied.

Behaviour:
- Reset: asynchronous, active-high, on rst_i; takes effect immediately regardless of state or outstanding fetch.
  - pc_o=RESET_PC, imem_req_o=0, instr_valid_o=0, redirect_pending_o=0, state=IDLE.
  - Any in-flight ack is discarded.
- States: IDLE, FETCH, HOLD.
  - IDLE: imem_req_o=0. Moves to FETCH next cycle if stall_i=0, else to HOLD.
  - FETCH: imem_req_o=1 and pc_o held stable until imem_ack_i.
    - stall_i does not withdraw an outstanding request.
    - On ack: go to HOLD if stall_i=1, else stay in FETCH and issue the next fetch in the next cycle (one fetch per ack, no bubble).
  - HOLD: imem_req_o=0. Moves to FETCH the cycle after stall_i=0.
- instr_valid_o = (state==FETCH) & imem_ack_i; combinational, same cycle as the ack.
- Target formation:
  - Jump target = {pc_plus4[31:28], jump_addr_i}, where pc_plus4 = pc_o+4 in the capture cycle.
  - Branch target = branch_target_i.
  - Bits [1:0] of every target are forced to 2'b00.
  - PC+4 wraps modulo 2^32 (0xFFFFFFFC -> 0x00000000).
- Redirect priority in one cycle: jump_i over branch_i. Across cycles the latest redirect overwrites any pending one.
- Next-PC update:
  - FETCH with ack: pc_o <= incoming redirect target if present, else pending target if present, else pc_o+4. Pending is cleared.
  - FETCH without ack: a redirect is stored as pending, redirect_pending_o=1 from the next cycle, and pc_o is unchanged.
  - IDLE/HOLD: a redirect loads pc_o directly next cycle; pending is cleared.
- Redirect coincident with rst_i is lost.

Optional Feature:
- Macro: DELAY_SLOT_EN.
- When defined:
  - Every redirect, in any state, is stored as pending; no direct pc_o load.
  - The first ack after capture advances pc_o to pc_o+4 (the delay-slot instruction).
  - The second ack loads the target and clears pending.
  - A newer redirect during the countdown replaces the target without restarting the countdown.
  - redirect_pending_o stays high until the target is loaded.
- When undefined: behaviour exactly as above, with no delay slot.

Test Plan:
- Reset with RESET_PC=0x00400000 -> pc_o=0x00400000, imem_req_o=0; one cycle later imem_req_o=1; ack every cycle -> pc_o sequence 0x00400004, 0x00400008.
- pc_o=0x40000010, jump_i=1, jump_addr_i=28'h0000100, ack in the same cycle -> pc_o=0x40000100 next cycle; jump_i and branch_i together with branch_target_i=0x8 -> jump wins.
- Ack withheld 3 cycles after branch_i with branch_target_i=0x00001234 -> redirect_pending_o=1 and pc_o stable; on ack, pc_o=0x00001234 (low bits forced to 00) and pending clears.
- stall_i high in FETCH with ack delayed 2 cycles -> imem_req_o held until the ack, then HOLD with imem_req_o=0; jump in HOLD loads pc_o next cycle; stall_i low -> FETCH.
- pc_o=0xFFFFFFFC with ack -> pc_o=0x00000000; rst_i asserted mid-FETCH with a redirect pending -> immediate pc_o=RESET_PC and redirect_pending_o=0.
- DELAY_SLOT_EN build: pc_o=0x100, jump to target 0x200 -> next ack gives pc_o=0x104, following ack gives pc_o=0x200.

Source files
------------

// File: rtl/pc_fetch_sequencer_if.sv
// Fetch-side bundle between control unit, instruction memory and pc_fetch_sequencer.
// req/ack: imem_req_o stays high with pc_o stable until imem_ack_i; a fetch completes in the cycle ack is seen with req high.
interface pc_fetch_sequencer_if;
    logic        stall_i;
    logic        jump_i;
    logic [27:0] jump_addr_i;
    logic        branch_i;
    logic [31:0] branch_target_i;
    logic        imem_ack_i;
    logic [31:0] pc_o;
    logic        imem_req_o;
    logic        instr_valid_o;
    logic        redirect_pending_o;
    logic [1:0]  state_dbg_o;

    modport master (
        input  stall_i, jump_i, jump_addr_i, branch_i, branch_target_i, imem_ack_i,
        output pc_o, imem_req_o, instr_valid_o, redirect_pending_o, state_dbg_o
    );

    modport slave (
        output stall_i, jump_i, jump_addr_i, branch_i, branch_target_i, imem_ack_i,
        input  pc_o, imem_req_o, instr_valid_o, redirect_pending_o, state_dbg_o
    );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Program counter owner and instruction-fetch sequencer with redirect capture.
// Optional DELAY_SLOT_EN: redirects take effect after one delay-slot fetch.
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic clk_i,
    input logic rst_i,
    pc_fetch_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tgt_q, tgt_d;
    logic        pend_q, pend_d;
    logic [31:0] pc_plus4;
    logic [31:0] redir_tgt;
    logic        redir;
    logic        ack;

    assign pc_plus4  = pc_q + 32'd4;
    assign redir     = bus.jump_i | bus.branch_i;
    // Jump keeps the region nibble of the sequential successor; both targets are word aligned.
    assign redir_tgt = bus.jump_i
                     ? (((pc_plus4 & 32'hF000_0000) | {4'h0, bus.jump_addr_i}) & 32'hFFFF_FFFC)
                     : (bus.branch_target_i & 32'hFFFF_FFFC);
    assign ack       = (state_q == FETCH) & bus.imem_ack_i;

`ifdef DELAY_SLOT_EN
    logic        slot_q, slot_d;
    logic        pend_n;
    logic        slot_n;
    logic [31:0] tgt_n;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        tgt_d   = tgt_q;
        unique case (state_q)
            IDLE:    state_d = bus.stall_i ? HOLD : FETCH;
            FETCH:   if (ack) state_d = bus.stall_i ? HOLD : FETCH;
            HOLD:    if (!bus.stall_i) state_d = FETCH;
            default: state_d = IDLE;
        endcase
`ifdef DELAY_SLOT_EN
        slot_d = slot_q;
        // A newer redirect replaces the target but keeps the running countdown.
        pend_n = pend_q | redir;
        tgt_n  = redir ? redir_tgt : tgt_q;
        slot_n = pend_q ? slot_q : redir;
        if (ack) begin
            if (pend_n && !slot_n) begin
                pc_d   = tgt_n;
                pend_d = 1'b0;
                slot_d = 1'b0;
            end else begin
                pc_d   = pc_plus4;
                pend_d = pend_n;
                tgt_d  = tgt_n;
                slot_d = 1'b0;
            end
        end else begin
            pend_d = pend_n;
            tgt_d  = tgt_n;
            slot_d = slot_n;
        end
`else
        if (ack) begin
            pc_d   = redir ? redir_tgt : (pend_q ? tgt_q : pc_plus4);
            pend_d = 1'b0;
        end else if (redir) begin
            if (state_q == FETCH) begin
                pend_d = 1'b1;
                tgt_d  = redir_tgt;
            end else begin
                pc_d   = redir_tgt;
                pend_d = 1'b0;
            end
        end
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            tgt_q   <= 32'h0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            pend_q  <= pend_d;
        end
    end

`ifdef DELAY_SLOT_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) slot_q <= 1'b0;
        else       slot_q <= slot_d;
    end
`endif

    assign bus.pc_o               = pc_q;
    assign bus.imem_req_o         = (state_q == FETCH);
    assign bus.instr_valid_o      = ack;
    assign bus.redirect_pending_o = pend_q;
    assign bus.state_dbg_o        = state_q;

endmodule
